// File: rtl/serial_add_collector.sv
// serial_add_collector: bit-serial LSB-first adder that collects WIDTH sum bits and flags completion.
// Define SERIAL_ADD_SAT_EN to make an overflowing result saturate to all ones.
module serial_add_collector #(
  parameter int WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         bit_valid,
  input  logic                         a_bit,
  input  logic                         b_bit,
  output logic                         busy,
  output logic                         done,
  output logic [WIDTH-1:0]             sum_out,
  output logic                         carry_out,
  output logic [$clog2(WIDTH+1)-1:0]   bit_count
);
  localparam int CW = $clog2(WIDTH+1);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  logic [1:0]       state;
  logic             carry;
  logic [WIDTH-1:0] shreg;
  logic             s;
  logic             c_nxt;
  logic             last;
  logic [WIDTH-1:0] sh_nxt;
  logic [WIDTH-1:0] res;
  assign s      = a_bit ^ b_bit ^ carry;
  assign c_nxt  = (a_bit & b_bit) | (carry & (a_bit ^ b_bit));
  assign sh_nxt = {s, shreg[WIDTH-1:1]};
  assign last   = bit_count == CW'(WIDTH-1);
`ifdef SERIAL_ADD_SAT_EN
  assign res = c_nxt ? '1 : sh_nxt;
`else
  assign res = sh_nxt;
`endif
  // start wins in every state, so a restart mid-SHIFT drops that cycle's pair
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum_out   <= '0;
      carry_out <= 1'b0;
      bit_count <= '0;
      carry     <= 1'b0;
      shreg     <= '0;
    end else if (start) begin
      state     <= SHIFT;
      busy      <= 1'b1;
      done      <= 1'b0;
      bit_count <= '0;
      carry     <= 1'b0;
      shreg     <= '0;
    end else if (state == SHIFT && bit_valid) begin
      carry     <= c_nxt;
      shreg     <= sh_nxt;
      bit_count <= bit_count + CW'(1);
      if (last) begin
        state     <= DONE;
        busy      <= 1'b0;
        done      <= 1'b1;
        sum_out   <= res;
        carry_out <= c_nxt;
      end
    end
  end
endmodule

// File: tb/tb_serial_add_collector.sv
// tb_serial_add_collector: randomized and directed serial additions checked against integer arithmetic.
module tb_serial_add_collector;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic bit_valid = 1'b0;
  logic a_bit = 1'b0;
  logic b_bit = 1'b0;
  logic busy, done, carry_out;
  logic [W-1:0] sum_out;
  logic [$clog2(W+1)-1:0] bit_count;
  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] prev_sum = '0;
  logic prev_carry = 1'b0;

  serial_add_collector #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .bit_valid(bit_valid), .a_bit(a_bit), .b_bit(b_bit),
    .busy(busy), .done(done), .sum_out(sum_out), .carry_out(carry_out), .bit_count(bit_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_sum"}, 32'(sum_out), 0);
    check({tag, "_carry"}, 32'(carry_out), 0);
    check({tag, "_cnt"}, 32'(bit_count), 0);
  endtask

  // start cycle carries a random valid pair that must be ignored, then n pairs with random gaps
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input int n, input int max_gap);
    @(negedge clk);
    start = 1'b1; bit_valid = 1'b1; a_bit = 1'($urandom); b_bit = 1'($urandom);
    @(negedge clk);
    start = 1'b0; bit_valid = 1'b0;
    check("start_busy", 32'(busy), 1);
    check("start_done", 32'(done), 0);
    check("start_cnt", 32'(bit_count), 0);
    check("hold_sum", 32'(sum_out), 32'(prev_sum));
    check("hold_carry", 32'(carry_out), 32'(prev_carry));
    for (int i = 0; i < n; i++) begin
      int gap = max_gap == 0 ? 0 : int'($urandom_range(max_gap));
      for (int g = 0; g < gap; g++) begin
        a_bit = 1'($urandom); b_bit = 1'($urandom);
        @(negedge clk);
      end
      bit_valid = 1'b1; a_bit = a[i]; b_bit = b[i];
      @(negedge clk);
      bit_valid = 1'b0;
      if (i < W - 1) check("mid_done", 32'(done), 0);
    end
  endtask

  task automatic add(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input int max_gap);
    int full;
    logic [W-1:0] es;
    logic ec;
    full = int'(a) + int'(b);
    ec = full >= (1 << W);
    es = W'(full);
`ifdef SERIAL_ADD_SAT_EN
    if (ec) es = '1;
`endif
    send(a, b, W, max_gap);
    check({tag, "_done"}, 32'(done), 1);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_sum"}, 32'(sum_out), 32'(es));
    check({tag, "_carry"}, 32'(carry_out), 32'(ec));
    check({tag, "_cnt"}, 32'(bit_count), W);
    bit_valid = 1'b1; a_bit = 1'b1; b_bit = 1'b1;
    repeat (2) @(negedge clk);
    bit_valid = 1'b0;
    check({tag, "_held_sum"}, 32'(sum_out), 32'(es));
    check({tag, "_held_cnt"}, 32'(bit_count), W);
    check({tag, "_held_done"}, 32'(done), 1);
    prev_sum = es;
    prev_carry = ec;
  endtask

  initial begin
    #2 check_reset_outputs("por");
    @(negedge clk) rst = 1'b0;
    add("d35_4a", 8'h35, 8'h4A, 0);
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_rst");
    @(negedge clk) rst = 1'b0;
    prev_sum = '0; prev_carry = 1'b0;
    add("dff_01", 8'hFF, 8'h01, 3);
    send(8'hAA, 8'h55, 4, 0);
    add("d0f_01", 8'h0F, 8'h01, 0);
    add("d80_80", 8'h80, 8'h80, 0);
    send(8'h12, 8'h34, 5, 1);
    #2 rst = 1'b1;
    #1 check_reset_outputs("mid_rst");
    @(negedge clk) rst = 1'b0;
    prev_sum = '0; prev_carry = 1'b0;
    add("d01_01", 8'h01, 8'h01, 0);
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(3) == 0) send(W'($urandom), W'($urandom), int'($urandom_range(W - 1)), 2);
      add("rnd", W'($urandom), W'($urandom), int'($urandom_range(3)));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
